// File: rtl/asconp_iter.sv
// Iterative Ascon-p permutation core: UROL rounds per clock, 1..12 rounds per request.
// Define ASCONP_LUT_SBOX_EN to replace the boolean S-box with a register-programmable 32x5 table.

`ifdef ASCONP_LUT_SBOX_EN
package asconp_reg_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;
endpackage
`endif

module asconp_iter #(
  parameter int UROL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef ASCONP_LUT_SBOX_EN
  input  asconp_reg_pkg::reg_req_t sbox_reg_req_i,
  output asconp_reg_pkg::reg_rsp_t sbox_reg_rsp_o,
`endif
  input  logic        start_i,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  if (!(UROL == 1 || UROL == 2 || UROL == 3 || UROL == 4 || UROL == 6)) begin : g_bad_urol
    $error("asconp_iter: UROL must be one of 1,2,3,4,6");
  end

  localparam logic [3:0] UROL_W = 4'(UROL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [4:0][63:0]  x_q, x_d;
  logic [3:0]        rc_q, rc_d;
  logic [3:0]        rem_q, rem_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [3:0]        nr_s;
  logic [4:0][63:0]  stage_s [UROL+1];

  function automatic logic [7:0] rc_f(input logic [3:0] r);
    return 8'hf0 - ({4'h0, r} * 8'h10) + {4'h0, r};
  endfunction

  function automatic logic [63:0] ror_f(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [4:0][63:0] linear_f(input logic [4:0][63:0] s);
    logic [4:0][63:0] o;
    o[0] = s[0] ^ ror_f(s[0], 19) ^ ror_f(s[0], 28);
    o[1] = s[1] ^ ror_f(s[1], 61) ^ ror_f(s[1], 39);
    o[2] = s[2] ^ ror_f(s[2], 1)  ^ ror_f(s[2], 6);
    o[3] = s[3] ^ ror_f(s[3], 10) ^ ror_f(s[3], 17);
    o[4] = s[4] ^ ror_f(s[4], 7)  ^ ror_f(s[4], 41);
    return o;
  endfunction

`ifdef ASCONP_LUT_SBOX_EN
  localparam logic [31:0][4:0] SBOX_INIT = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
  };

  logic [31:0][4:0] lut_q, lut_d;
  logic             reg_err_s;

  // Bit i of x0 is the MSB of the table index and receives the MSB of the entry.
  function automatic logic [4:0][63:0] sbox_f(input logic [4:0][63:0] s,
                                               input logic [31:0][4:0] tbl);
    logic [4:0][63:0] o;
    logic [4:0]       idx;
    logic [4:0]       ent;
    o = s;
    for (int i = 0; i < 64; i++) begin
      idx = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
      ent = tbl[idx];
      o[0][i] = ent[4];
      o[1][i] = ent[3];
      o[2][i] = ent[2];
      o[3][i] = ent[1];
      o[4][i] = ent[0];
    end
    return o;
  endfunction

  function automatic logic [4:0][63:0] round_f(input logic [4:0][63:0] s, input logic [3:0] r,
                                               input logic [31:0][4:0] tbl);
    logic [4:0][63:0] t;
    t    = s;
    t[2] = t[2] ^ {56'h0, rc_f(r)};
    return linear_f(sbox_f(t, tbl));
  endfunction

  // Register port: table writes and combinational read-back.
  always_comb begin
    reg_err_s = (sbox_reg_req_i.addr >= 32'h0000_0080);
    lut_d     = lut_q;
    if (sbox_reg_req_i.valid && sbox_reg_req_i.write && !reg_err_s) begin
      lut_d[sbox_reg_req_i.addr[6:2]] = sbox_reg_req_i.wdata[4:0];
    end else begin
      lut_d = lut_q;
    end
    sbox_reg_rsp_o.ready = 1'b1;
    sbox_reg_rsp_o.error = reg_err_s;
    sbox_reg_rsp_o.rdata = {27'h0, lut_q[sbox_reg_req_i.addr[6:2]]};
  end
`else
  function automatic logic [4:0][63:0] sbox_f(input logic [4:0][63:0] s);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    a0 = s[0] ^ s[4];
    a1 = s[1];
    a2 = s[2] ^ s[1];
    a3 = s[3];
    a4 = s[4] ^ s[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    return {a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [4:0][63:0] round_f(input logic [4:0][63:0] s, input logic [3:0] r);
    logic [4:0][63:0] t;
    t    = s;
    t[2] = t[2] ^ {56'h0, rc_f(r)};
    return linear_f(sbox_f(t));
  endfunction
`endif

  // Unrolled round chain; stages past the remaining count pass the state through.
  always_comb begin
    stage_s[0] = x_q;
    for (int k = 0; k < UROL; k++) begin
      if (4'(k) < rem_q) begin
`ifdef ASCONP_LUT_SBOX_EN
        stage_s[k+1] = round_f(stage_s[k], rc_q + 4'(k), lut_q);
`else
        stage_s[k+1] = round_f(stage_s[k], rc_q + 4'(k));
`endif
      end else begin
        stage_s[k+1] = stage_s[k];
      end
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    nr_s    = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
    state_d = state_q;
    x_d     = x_q;
    rc_d    = rc_q;
    rem_d   = rem_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (start_i) begin
          x_d     = {x4_i, x3_i, x2_i, x1_i, x0_i};
          rc_d    = 4'd12 - nr_s;
          rem_d   = nr_s;
          ready_d = 1'b0;
          if (nr_s == 4'd0) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_d     = stage_s[UROL];
        ready_d = 1'b0;
        if (rem_q <= UROL_W) begin
          rc_d    = rc_q + rem_q;
          rem_d   = 4'd0;
          state_d = ST_DONE;
          valid_d = 1'b1;
        end else begin
          rc_d    = rc_q + UROL_W;
          rem_d   = rem_q - UROL_W;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      rc_q    <= 4'd0;
      rem_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef ASCONP_LUT_SBOX_EN
      lut_q   <= SBOX_INIT;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rc_q    <= rc_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
`ifdef ASCONP_LUT_SBOX_EN
      lut_q   <= lut_d;
`endif
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign x0_o    = x_q[0];
  assign x1_o    = x_q[1];
  assign x2_o    = x_q[2];
  assign x3_o    = x_q[3];
  assign x4_o    = x_q[4];

endmodule

// File: tb/tb_asconp_iter.sv
// Scoreboard bench for asconp_iter: a UROL=1 and a UROL=4 instance against a table-driven Ascon-p model.
// Builds with or without ASCONP_LUT_SBOX_EN.

module tb_asconp_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       start_v;
  logic [3:0]       rounds;
  logic [4:0][63:0] xin;
  wire  [1:0]       ready_v;
  wire  [1:0]       valid_v;
  wire  [4:0][63:0] xo1;
  wire  [4:0][63:0] xo4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0][63:0] x;
    int               lat;
  } exp_t;

  exp_t sb1[$];
  exp_t sb4[$];
  logic [4:0] sbox_tbl [32];

`ifdef ASCONP_LUT_SBOX_EN
  asconp_reg_pkg::reg_req_t req1, req4;
  asconp_reg_pkg::reg_rsp_t rsp1, rsp4;
`endif

  asconp_iter #(.UROL(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
`ifdef ASCONP_LUT_SBOX_EN
    .sbox_reg_req_i(req1), .sbox_reg_rsp_o(rsp1),
`endif
    .start_i(start_v[0]), .rounds_i(rounds),
    .x0_i(xin[0]), .x1_i(xin[1]), .x2_i(xin[2]), .x3_i(xin[3]), .x4_i(xin[4]),
    .ready_o(ready_v[0]), .valid_o(valid_v[0]),
    .x0_o(xo1[0]), .x1_o(xo1[1]), .x2_o(xo1[2]), .x3_o(xo1[3]), .x4_o(xo1[4])
  );

  asconp_iter #(.UROL(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
`ifdef ASCONP_LUT_SBOX_EN
    .sbox_reg_req_i(req4), .sbox_reg_rsp_o(rsp4),
`endif
    .start_i(start_v[1]), .rounds_i(rounds),
    .x0_i(xin[0]), .x1_i(xin[1]), .x2_i(xin[2]), .x3_i(xin[3]), .x4_i(xin[4]),
    .ready_o(ready_v[1]), .valid_o(valid_v[1]),
    .x0_o(xo4[0]), .x1_o(xo4[1]), .x2_o(xo4[2]), .x3_o(xo4[3]), .x4_o(xo4[4])
  );

  // Reference permutation: S-box by table lookup, rotations by bit indexing.
  function automatic logic [4:0][63:0] model_p(input logic [4:0][63:0] s_in, input int nr,
                                               input bit ident);
    logic [4:0][63:0] s, t;
    logic [4:0] idx, o;
    int ra [5];
    int rb [5];
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    s = s_in;
    for (int r = 12 - nr; r < 12; r++) begin
      s[2][7:0] = s[2][7:0] ^ 8'(240 - 15 * r);
      for (int i = 0; i < 64; i++) begin
        idx = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
        o = ident ? idx : sbox_tbl[idx];
        t[0][i] = o[4];
        t[1][i] = o[3];
        t[2][i] = o[2];
        t[3][i] = o[1];
        t[4][i] = o[0];
      end
      for (int w = 0; w < 5; w++) begin
        for (int j = 0; j < 64; j++) begin
          s[w][j] = t[w][j] ^ t[w][(j + ra[w]) % 64] ^ t[w][(j + rb[w]) % 64];
        end
      end
    end
    return s;
  endfunction

  function automatic logic [4:0][63:0] rand_state();
    logic [4:0][63:0] s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (ready_v !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", ready_v); end
    checks++;
    if (valid_v !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", valid_v); end
    checks++;
    if (xo1 !== '0) begin errors++; $display("FAIL reset_x_u1 got %h want 0", xo1); end
    checks++;
    if (xo4 !== '0) begin errors++; $display("FAIL reset_x_u4 got %h want 0", xo4); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Push the expectation, launch one request on instance w, pop and compare at valid_o.
  task automatic run_op(input int w, input logic [4:0][63:0] x, input logic [3:0] nr,
                        input bit ident, input string name);
    exp_t e, g;
    int eff, u, cnt;
    logic [4:0][63:0] got;
    eff   = (nr > 4'd12) ? 12 : int'(nr);
    u     = (w == 0) ? 1 : 4;
    e.x   = model_p(x, eff, ident);
    e.lat = (eff + u - 1) / u + 1;
    if (w == 0) sb1.push_back(e); else sb4.push_back(e);
    xin = x;
    rounds = nr;
    start_v[w] = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      start_v[w] = 1'b0;
      cnt++;
    end while (valid_v[w] !== 1'b1 && cnt < 40);
    if (w == 0) g = sb1.pop_front(); else g = sb4.pop_front();
    got = (w == 0) ? xo1 : xo4;
    checks++;
    if (cnt !== g.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, cnt, g.lat); end
    checks++;
    if (got !== g.x) begin errors++; $display("FAIL %s state got %h want %h", name, got, g.x); end
    @(posedge clk);
    #1;
    checks++;
    if (valid_v[w] !== 1'b0 || ready_v[w] !== 1'b1) begin
      errors++;
      $display("FAIL %s post_done got valid=%b ready=%b want valid=0 ready=1", name, valid_v[w], ready_v[w]);
    end
  endtask

  task automatic test_rounds();
    logic [4:0][63:0] r;
    r = rand_state();
    run_op(0, '0, 4'd12, 1'b0, "p12_zero_u1");
    run_op(1, '0, 4'd12, 1'b0, "p12_zero_u4");
    run_op(0, '0, 4'd8, 1'b0, "p8_zero_u1");
    run_op(0, r, 4'd6, 1'b0, "p6_rand_u1");
    run_op(1, r, 4'd6, 1'b0, "p6_rand_u4");
    run_op(1, r, 4'd7, 1'b0, "p7_rand_u4");
    run_op(1, rand_state(), 4'd12, 1'b0, "p12_rand_u4");
  endtask

  task automatic test_boundary();
    logic [4:0][63:0] r;
    r = rand_state();
    run_op(0, r, 4'd0, 1'b0, "nr0_u1");
    run_op(1, r, 4'd0, 1'b0, "nr0_u4");
    run_op(0, r, 4'd15, 1'b0, "nr15_u1");
    run_op(1, r, 4'd13, 1'b0, "nr13_u4");
    run_op(1, r, 4'd1, 1'b0, "nr1_u4");
  endtask

  task automatic test_back_to_back();
    logic [4:0][63:0] a, b;
    exp_t e, g;
    int cnt;
    a = rand_state();
    b = rand_state();
    e.x = model_p(a, 5, 1'b0);
    e.lat = 6;
    sb1.push_back(e);
    xin = a;
    rounds = 4'd5;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    cnt = 1;
    while (valid_v[0] !== 1'b1 && cnt < 40) begin
      xin = rand_state();
      rounds = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      cnt++;
    end
    g = sb1.pop_front();
    checks++;
    if (cnt !== g.lat) begin errors++; $display("FAIL held_a latency got %0d want %0d", cnt, g.lat); end
    checks++;
    if (xo1 !== g.x) begin errors++; $display("FAIL held_a state got %h want %h", xo1, g.x); end
    xin = rand_state();
    rounds = 4'd12;
    @(posedge clk);
    #1;
    checks++;
    if (valid_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL held_idle got valid=%b ready=%b want valid=0 ready=1", valid_v[0], ready_v[0]);
    end
    checks++;
    if (xo1 !== g.x) begin errors++; $display("FAIL held_hold state got %h want %h", xo1, g.x); end
    e.x = model_p(b, 3, 1'b0);
    e.lat = 4;
    sb1.push_back(e);
    xin = b;
    rounds = 4'd3;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      cnt++;
    end while (valid_v[0] !== 1'b1 && cnt < 40);
    g = sb1.pop_front();
    checks++;
    if (cnt !== g.lat) begin errors++; $display("FAIL held_b latency got %0d want %0d", cnt, g.lat); end
    checks++;
    if (xo1 !== g.x) begin errors++; $display("FAIL held_b state got %h want %h", xo1, g.x); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_midrun_reset();
    bit seen;
    xin = rand_state();
    rounds = 4'd12;
    start_v = 2'b11;
    @(posedge clk);
    #1;
    start_v = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ready_v !== 2'b11 || valid_v !== 2'b00) begin
      errors++;
      $display("FAIL midrun_rst_ctl got ready=%b valid=%b want ready=11 valid=00", ready_v, valid_v);
    end
    checks++;
    if (xo1 !== '0 || xo4 !== '0) begin errors++; $display("FAIL midrun_rst_x got %h %h want 0", xo1, xo4); end
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_v !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrun_no_valid got valid pulse want none"); end
  endtask

`ifdef ASCONP_LUT_SBOX_EN
  task automatic test_lut();
    for (int k = 0; k < 32; k++) begin
      req1.valid = 1'b1;
      req1.write = 1'b1;
      req1.addr  = 32'(k * 4);
      req1.wdata = 32'(k);
      @(posedge clk);
      #1;
    end
    req1.valid = 1'b0;
    req1.write = 1'b0;
    req1.addr  = 32'h08;
    #1;
    checks++;
    if (rsp1.rdata !== 32'h2 || rsp1.error !== 1'b0 || rsp1.ready !== 1'b1) begin
      errors++;
      $display("FAIL lut_read got rdata=%h err=%b rdy=%b want 2 0 1", rsp1.rdata, rsp1.error, rsp1.ready);
    end
    req1.addr = 32'h80;
    #1;
    checks++;
    if (rsp1.error !== 1'b1) begin errors++; $display("FAIL lut_err got %b want 1", rsp1.error); end
    req1.addr = 32'h0;
    run_op(0, rand_state(), 4'd1, 1'b1, "lut_ident");
  endtask
`endif

  initial begin
    sbox_tbl = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    rst = 1'b1;
    start_v = 2'b00;
    rounds = 4'd0;
    xin = '0;
`ifdef ASCONP_LUT_SBOX_EN
    req1 = '0;
    req4 = '0;
`endif
    test_reset();
    test_rounds();
    test_boundary();
    test_back_to_back();
    test_midrun_reset();
`ifdef ASCONP_LUT_SBOX_EN
    test_lut();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
